// File: rtl/noc_pkg.sv
// Shared NoC constants for NIC-side traffic drivers.
// Register map, packet fields and driver FSM states.
package noc_pkg;

  localparam int PACKET_WIDTH = 64;

  localparam logic [1:0] NIC_IN_BUF   = 2'b00;
  localparam logic [1:0] NIC_IN_STAT  = 2'b01;
  localparam logic [1:0] NIC_OUT_BUF  = 2'b10;
  localparam logic [1:0] NIC_OUT_STAT = 2'b11;

  localparam int PKT_HDR_LSB = 32;
  localparam int PKT_SIG_LSB = 16;
  localparam int PKT_SEQ_LSB = 0;

  localparam logic [15:0] PKT_SIG = 16'hA5A5;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_TX_POLL,
    ST_TX_CHK,
    ST_TX_WR,
    ST_RX_POLL,
    ST_RX_CHK,
    ST_RX_RD,
    ST_RX_CAP,
    ST_DONE
  } pe_state_e;

  function automatic logic [3:0] abs_diff2(
    input logic [1:0] a,
    input logic [1:0] b
  );
    logic [1:0] d;
    d = (a > b) ? (a - b) : (b - a);
    return {2'b00, d};
  endfunction

endpackage

// File: rtl/pkt_hdr_gen.sv
// Combinational packet header builder (bits 63:32).
// Routing direction, hop distance and source id.
module pkt_hdr_gen
  import noc_pkg::*;
(
  input  logic [1:0]  i_src_x,
  input  logic [1:0]  i_src_y,
  input  logic [1:0]  i_dst_x,
  input  logic [1:0]  i_dst_y,
  output logic [31:0] o_hdr
);

  logic w_x_dir;
  logic w_y_dir;

  assign w_x_dir = (i_dst_x > i_src_x);
  assign w_y_dir = (i_dst_y > i_src_y);

  assign o_hdr = {
    1'b0,
    w_x_dir,
    w_y_dir,
    5'b00000,
    abs_diff2(i_dst_x, i_src_x),
    abs_diff2(i_dst_y, i_src_y),
    i_src_y,
    i_src_x,
    4'h0,
    8'h00
  };

endmodule

// File: rtl/nic_pe_driver.sv
// PE stand-in driving a NIC CPU port: sends NUM_TX
// packets, drains and checks received packets.
module nic_pe_driver #(
  parameter int          PACKET_WIDTH = noc_pkg::PACKET_WIDTH,
  parameter int unsigned SRC_X        = 0,
  parameter int unsigned SRC_Y        = 0,
  parameter int unsigned DST_X        = 3,
  parameter int unsigned DST_Y        = 3,
  parameter int unsigned NUM_TX       = 8,
  parameter int unsigned NUM_RX       = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  output logic [1:0]              addr,
  output logic [PACKET_WIDTH-1:0] d_in,
  input  logic [PACKET_WIDTH-1:0] d_out,
  output logic                    nicEn,
  output logic                    nicEnWR,
  output logic [7:0]              tx_count,
  output logic [7:0]              rx_count,
  output logic                    rx_err,
  output logic [63:0]             rx_last,
  output logic                    done
);
  import noc_pkg::*;

  localparam logic [1:0] L_SX  = SRC_X[1:0];
  localparam logic [1:0] L_SY  = SRC_Y[1:0];
  localparam logic [1:0] L_DX  = DST_X[1:0];
  localparam logic [1:0] L_DY  = DST_Y[1:0];
  localparam logic [7:0] L_NTX = NUM_TX[7:0];
  localparam logic [7:0] L_NRX = NUM_RX[7:0];

  pe_state_e r_state;
  pe_state_e w_state_nx;

  logic [1:0]              r_addr, w_addr_nx;
  logic [PACKET_WIDTH-1:0] r_d_in, w_d_in_nx;
  logic                    r_en, w_en_nx;
  logic                    r_wr, w_wr_nx;
  logic [7:0]              r_tx, w_tx_nx;
  logic [7:0]              r_rx, w_rx_nx;
  logic                    r_err, w_err_nx;
  logic [63:0]             r_last, w_last_nx;
  logic                    r_done, w_done_nx;

  logic [31:0] w_hdr;
  logic [63:0] w_pkt;

  function automatic logic [7:0] sat_inc(
    input logic [7:0] v
  );
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  pkt_hdr_gen u_hdr (
    .i_src_x (L_SX),
    .i_src_y (L_SY),
    .i_dst_x (L_DX),
    .i_dst_y (L_DY),
    .o_hdr   (w_hdr)
  );

  // Outgoing packet for the current sequence number
  always_comb begin
    w_pkt = '0;
    w_pkt[PKT_HDR_LSB +: 32] = w_hdr;
    w_pkt[PKT_SIG_LSB +: 16] = PKT_SIG;
    w_pkt[PKT_SEQ_LSB +: 16] = {8'h00, r_tx};
  end

  // Next state plus counter and receive-status updates
  always_comb begin
    w_state_nx = r_state;
    w_tx_nx    = r_tx;
    w_rx_nx    = r_rx;
    w_err_nx   = r_err;
    w_last_nx  = r_last;
    case (r_state)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          w_tx_nx    = '0;
          w_rx_nx    = '0;
          w_err_nx   = 1'b0;
          w_last_nx  = '0;
          w_state_nx = ST_TX_POLL;
        end
      end
      ST_TX_POLL: begin
        w_state_nx = (r_tx == L_NTX) ?
                     ST_RX_POLL : ST_TX_CHK;
      end
      ST_TX_CHK: begin
        w_state_nx = d_out[0] ? ST_RX_POLL : ST_TX_WR;
      end
      ST_TX_WR: begin
        w_tx_nx    = sat_inc(r_tx);
        w_state_nx = ST_RX_POLL;
      end
      ST_RX_POLL: begin
        w_state_nx = ST_RX_CHK;
      end
      ST_RX_CHK: begin
        if (d_out[0])
          w_state_nx = ST_RX_RD;
        else if ((r_tx == L_NTX) && (r_rx >= L_NRX))
          w_state_nx = ST_DONE;
        else
          w_state_nx = ST_TX_POLL;
      end
      ST_RX_RD: begin
        w_state_nx = ST_RX_CAP;
      end
      ST_RX_CAP: begin
        w_last_nx = d_out[63:0];
        w_rx_nx   = sat_inc(r_rx);
        if ((d_out[PKT_SIG_LSB +: 16] != PKT_SIG) ||
            (r_rx == L_NRX))
          w_err_nx = 1'b1;
        w_state_nx = ST_TX_POLL;
      end
      default: w_state_nx = ST_IDLE;
    endcase
  end

  // NIC access for the cycle being entered, so reads
  // return data in the following state
  always_comb begin
    w_en_nx   = 1'b0;
    w_wr_nx   = 1'b0;
    w_addr_nx = r_addr;
    w_d_in_nx = r_d_in;
    w_done_nx = (w_state_nx == ST_DONE);
    unique case (1'b1)
      (w_state_nx == ST_TX_POLL): begin
        if (w_tx_nx != L_NTX) begin
          w_en_nx   = 1'b1;
          w_addr_nx = NIC_OUT_STAT;
        end
      end
      (w_state_nx == ST_TX_WR): begin
        w_en_nx   = 1'b1;
        w_wr_nx   = 1'b1;
        w_addr_nx = NIC_OUT_BUF;
        w_d_in_nx = w_pkt;
      end
      (w_state_nx == ST_RX_POLL): begin
        w_en_nx   = 1'b1;
        w_addr_nx = NIC_IN_STAT;
      end
      (w_state_nx == ST_RX_RD): begin
        w_en_nx   = 1'b1;
        w_addr_nx = NIC_IN_BUF;
      end
      default: ;
    endcase
  end

  // State and registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
      r_addr  <= '0;
      r_d_in  <= '0;
      r_en    <= 1'b0;
      r_wr    <= 1'b0;
      r_tx    <= '0;
      r_rx    <= '0;
      r_err   <= 1'b0;
      r_last  <= '0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_addr  <= w_addr_nx;
      r_d_in  <= w_d_in_nx;
      r_en    <= w_en_nx;
      r_wr    <= w_wr_nx;
      r_tx    <= w_tx_nx;
      r_rx    <= w_rx_nx;
      r_err   <= w_err_nx;
      r_last  <= w_last_nx;
      r_done  <= w_done_nx;
    end
  end

  assign addr     = r_addr;
  assign d_in     = r_d_in;
  assign nicEn    = r_en;
  assign nicEnWR  = r_wr;
  assign tx_count = r_tx;
  assign rx_count = r_rx;
  assign rx_err   = r_err;
  assign rx_last  = r_last;
  assign done     = r_done;

endmodule

// File: tb/tb_nic_pe_driver.sv
// Bench for nic_pe_driver: NIC behavioural model,
// packet reference function and scoreboard.
module tb_nic_pe_driver;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  logic        a_start, b_start, c_start;
  logic [1:0]  a_addr, b_addr, c_addr;
  logic [63:0] a_d_in, b_d_in, c_d_in;
  logic [63:0] a_d_out, b_d_out, c_d_out;
  logic        a_en, b_en, c_en;
  logic        a_wr, b_wr, c_wr;
  logic [7:0]  a_tx, b_tx, c_tx;
  logic [7:0]  a_rx, b_rx, c_rx;
  logic        a_err, b_err, c_err;
  logic [63:0] a_last, b_last, c_last;
  logic        a_done, b_done, c_done;

  assign b_d_out = '0;
  assign c_d_out = '0;

  nic_pe_driver #(
    .PACKET_WIDTH(64), .SRC_X(0), .SRC_Y(0),
    .DST_X(3), .DST_Y(3), .NUM_TX(8), .NUM_RX(8)
  ) u_dut_a (
    .clk(clk), .reset(rst_n), .start(a_start),
    .addr(a_addr), .d_in(a_d_in), .d_out(a_d_out),
    .nicEn(a_en), .nicEnWR(a_wr),
    .tx_count(a_tx), .rx_count(a_rx),
    .rx_err(a_err), .rx_last(a_last), .done(a_done)
  );

  nic_pe_driver #(
    .PACKET_WIDTH(64), .SRC_X(2), .SRC_Y(1),
    .DST_X(0), .DST_Y(3), .NUM_TX(3), .NUM_RX(0)
  ) u_dut_b (
    .clk(clk), .reset(rst_n), .start(b_start),
    .addr(b_addr), .d_in(b_d_in), .d_out(b_d_out),
    .nicEn(b_en), .nicEnWR(b_wr),
    .tx_count(b_tx), .rx_count(b_rx),
    .rx_err(b_err), .rx_last(b_last), .done(b_done)
  );

  nic_pe_driver #(
    .PACKET_WIDTH(64), .SRC_X(0), .SRC_Y(0),
    .DST_X(3), .DST_Y(3), .NUM_TX(0), .NUM_RX(0)
  ) u_dut_c (
    .clk(clk), .reset(rst_n), .start(c_start),
    .addr(c_addr), .d_in(c_d_in), .d_out(c_d_out),
    .nicEn(c_en), .nicEnWR(c_wr),
    .tx_count(c_tx), .rx_count(c_rx),
    .rx_err(c_err), .rx_last(c_last), .done(c_done)
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(
    input string       tag,
    input logic [63:0] got,
    input logic [63:0] exp
  );
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h",
               tag, got, exp);
    end
  endtask

  // Reference packet built from the field rules
  function automatic logic [63:0] exp_pkt(
    input int sx, input int sy,
    input int dx, input int dy, input int seq
  );
    logic [63:0] p;
    p = '0;
    p[62] = (dx > sx);
    p[61] = (dy > sy);
    p[55:52] = 4'((dx > sx) ? dx - sx : sx - dx);
    p[51:48] = 4'((dy > sy) ? dy - sy : sy - dy);
    p[47:40] = 8'(sy * 64 + sx * 16);
    p[31:16] = 16'hA5A5;
    p[15:0]  = 16'(seq);
    return p;
  endfunction

  // NIC model for instance A
  logic [63:0] rx_q[$];
  logic [63:0] wr_q[$];
  int full_left;
  bit loopback;
  bit last_full;
  bit expect_wr;
  int acc_cnt = 0;
  int viol = 0;
  int rx_poll_full;

  always @(posedge clk) begin
    if (a_wr && !a_en) viol++;
    if (a_en) begin
      acc_cnt++;
      if (expect_wr && !(a_wr && a_addr == 2'b10))
        viol++;
      expect_wr = 0;
      if (a_wr) begin
        if (a_addr != 2'b10 || last_full) viol++;
        wr_q.push_back(a_d_in);
        if (loopback) rx_q.push_back(a_d_in);
      end else begin
        case (a_addr)
          2'b00: begin
            if (rx_q.size() > 0)
              a_d_out <= rx_q.pop_front();
            else begin
              a_d_out <= '0;
              viol++;
            end
          end
          2'b01: begin
            a_d_out <= {63'h0, rx_q.size() != 0};
            if (last_full) rx_poll_full++;
          end
          2'b11: begin
            if (full_left > 0) begin
              a_d_out <= 64'h1;
              full_left--;
              last_full = 1;
            end else begin
              a_d_out <= 64'h0;
              last_full = 0;
              expect_wr = 1;
            end
          end
          default: viol++;
        endcase
      end
    end
  end

  logic [63:0] b_wr_q[$];
  int c_wr_cnt = 0;

  always @(posedge clk) begin
    if (b_en && b_wr) b_wr_q.push_back(b_d_in);
    if (c_en && c_wr) c_wr_cnt++;
  end

  task automatic model_reset(input int fl, input bit lb);
    rx_q.delete();
    wr_q.delete();
    full_left    = fl;
    loopback     = lb;
    last_full    = 0;
    expect_wr    = 0;
    rx_poll_full = 0;
  endtask

  task automatic pulse_a_start;
    @(negedge clk) a_start = 1'b1;
    @(negedge clk) a_start = 1'b0;
  endtask

  task automatic wait_a_done(
    input int limit, output bit ok
  );
    ok = 0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (a_done) begin
        ok = 1;
        break;
      end
    end
  endtask

  task automatic run_a(
    input string nm, input int fl, input bit lb,
    input int npre, input int bad_at,
    input bit first_chk
  );
    logic [63:0] p;
    logic [63:0] exp_last;
    int exp_rx;
    bit exp_err;
    bit ok;
    int acc0;
    model_reset(fl, lb);
    exp_last = '0;
    exp_err  = 0;
    for (int i = 0; i < npre; i++) begin
      p = {$urandom, $urandom};
      p[31:16] = (i == bad_at) ? 16'h1234 : 16'hA5A5;
      if (i == bad_at) exp_err = 1;
      rx_q.push_back(p);
      exp_last = p;
    end
    exp_rx = npre + (lb ? 8 : 0);
    if (exp_rx > 8) exp_err = 1;
    if (lb) exp_last = exp_pkt(0, 0, 3, 3, 7);
    pulse_a_start();
    wait_a_done(3000, ok);
    chk({nm, "_done"}, 64'(ok), 64'd1);
    chk({nm, "_tx"}, 64'(a_tx), 64'd8);
    chk({nm, "_rx"}, 64'(a_rx), 64'(exp_rx));
    chk({nm, "_err"}, 64'(a_err), 64'(exp_err));
    chk({nm, "_last"}, a_last, exp_last);
    chk({nm, "_nwr"}, 64'(wr_q.size()), 64'd8);
    for (int i = 0; i < wr_q.size(); i++)
      chk({nm, "_pkt"}, wr_q[i], exp_pkt(0, 0, 3, 3, i));
    if (first_chk && wr_q.size() > 0)
      chk("first_wr", wr_q[0], 64'h6033_0000_A5A5_0000);
    if (fl > 0)
      chk({nm, "_rxpoll_full"},
          64'(rx_poll_full >= fl), 64'd1);
    chk({nm, "_proto"}, 64'(viol), 64'd0);
    acc0 = acc_cnt;
    repeat (10) @(negedge clk);
    chk({nm, "_idle_acc"}, 64'(acc_cnt - acc0), 64'd0);
    chk({nm, "_done_hold"}, 64'(a_done), 64'd1);
    chk({nm, "_err_hold"}, 64'(a_err), 64'(exp_err));
  endtask

  initial begin
    bit ok;
    int acc0;
    int fl, npre, bad;
    bit lb;
    rst_n   = 1'b0;
    a_start = 1'b0;
    b_start = 1'b0;
    c_start = 1'b0;
    a_d_out = '0;
    model_reset(0, 0);
    repeat (3) @(negedge clk);
    chk("rst_addr", 64'(a_addr), 64'd0);
    chk("rst_d_in", a_d_in, 64'd0);
    chk("rst_en", 64'(a_en), 64'd0);
    chk("rst_wr", 64'(a_wr), 64'd0);
    chk("rst_tx", 64'(a_tx), 64'd0);
    chk("rst_rx", 64'(a_rx), 64'd0);
    chk("rst_err", 64'(a_err), 64'd0);
    chk("rst_last", a_last, 64'd0);
    chk("rst_done", 64'(a_done), 64'd0);
    @(negedge clk) rst_n = 1'b1;

    // Abort in the middle of the first write
    model_reset(0, 0);
    pulse_a_start();
    ok = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (a_en && a_wr) begin
        ok = 1;
        break;
      end
    end
    chk("abort_wr_seen", 64'(ok), 64'd1);
    chk("abort_wr_data", a_d_in, exp_pkt(0, 0, 3, 3, 0));
    #1 rst_n = 1'b0;
    #1;
    acc0 = acc_cnt;
    chk("abort_en", 64'(a_en), 64'd0);
    chk("abort_wr", 64'(a_wr), 64'd0);
    chk("abort_addr", 64'(a_addr), 64'd0);
    chk("abort_d_in", a_d_in, 64'd0);
    chk("abort_tx", 64'(a_tx), 64'd0);
    @(negedge clk) rst_n = 1'b1;
    model_reset(0, 0);
    repeat (20) @(negedge clk);
    chk("abort_no_acc", 64'(acc_cnt - acc0), 64'd0);
    chk("abort_done", 64'(a_done), 64'd0);

    run_a("loop8", 0, 1, 0, -1, 1);
    chk("loop8_seq", 64'(a_last[15:0]), 64'd7);
    run_a("full5", 5, 1, 0, -1, 0);
    run_a("badsig", 0, 0, 8, 3, 0);
    for (int r = 0; r < 4; r++) begin
      fl   = $urandom_range(0, 6);
      lb   = 1'($urandom_range(0, 1));
      npre = lb ? $urandom_range(0, 2)
                : $urandom_range(8, 10);
      bad  = -1;
      if ($urandom_range(0, 2) == 0 && npre > 0)
        bad = $urandom_range(0, npre - 1);
      run_a("rand", fl, lb, npre, bad, 0);
    end

    // B sends three packets; C has nothing to do
    @(negedge clk) begin
      b_start = 1'b1;
      c_start = 1'b1;
    end
    @(negedge clk) begin
      b_start = 1'b0;
      c_start = 1'b0;
    end
    ok = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (c_done) begin
        ok = 1;
        break;
      end
    end
    chk("c_done_3cyc", 64'(ok), 64'd1);
    chk("c_tx", 64'(c_tx), 64'd0);
    chk("c_nwr", 64'(c_wr_cnt), 64'd0);
    ok = 0;
    for (int i = 0; i < 300; i++) begin
      if (b_done) begin
        ok = 1;
        break;
      end
      @(negedge clk);
    end
    chk("b_done", 64'(ok), 64'd1);
    chk("b_tx", 64'(b_tx), 64'd3);
    chk("b_rx", 64'(b_rx), 64'd0);
    chk("b_err", 64'(b_err), 64'd0);
    chk("b_nwr", 64'(b_wr_q.size()), 64'd3);
    for (int i = 0; i < b_wr_q.size(); i++)
      chk("b_pkt", b_wr_q[i], exp_pkt(2, 1, 0, 3, i));

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/nic_pe_driver.md
# nic_pe_driver

Processing-element stand-in that drives the CPU side of one mesh node's NIC, whose CPU interface is otherwise left unconnected in the mesh rows. After `start`, it injects a fixed number of packets toward a parameterised destination router, drains and checks every packet the NIC receives, and reports counts and status. It is instantiated once per node, beside each `nic`, and provides self-checking traffic for mesh bring-up.

## Interface
- `PACKET_WIDTH`, 64, packet and NIC data width; only 64 is supported.
- `SRC_X`, 0, this node's column (2 bits).
- `SRC_Y`, 0, this node's row (2 bits).
- `DST_X`, 3, destination column (2 bits).
- `DST_Y`, 3, destination row (2 bits).
- `NUM_TX`, 8, number of packets to send, 0..255.
- `NUM_RX`, 8, number of packets expected, 0..255.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-low. `reset`=0 clears all state.
- `start` in 1: one-cycle pulse that starts a run. Sampled only in IDLE and DONE.
- `addr` out 2: NIC register select.
- `d_in` out 64: write data to the NIC.
- `d_out` in 64: read data from the NIC.
- `nicEn` out 1: NIC access enable.
- `nicEnWR` out 1: 1 = write, 0 = read. Valid only with `nicEn`.
- `tx_count` out 8: packets written so far.
- `rx_count` out 8: packets read so far.
- `rx_err` out 1: sticky; set on any bad received packet.
- `rx_last` out 64: last packet received.
- `done` out 1: high in DONE.

## Operation

NIC register map:
- 00: input buffer, read.
- 01: input status, read; `d_out[0]`=1 means a packet is waiting.
- 10: output buffer, write.
- 11: output status, read; `d_out[0]`=1 means the output buffer is full.

TX packet format:
- [63] vc = 0.
- [62] x direction: 1 when `DST_X`>`SRC_X`.
- [61] y direction: 1 when `DST_Y`>`SRC_Y`.
- [60:56] = 0.
- [55:52] |`DST_X`-`SRC_X`|.
- [51:48] |`DST_Y`-`SRC_Y`|.
- [47:40] {`SRC_Y`,`SRC_X`,4'h0}.
- [39:32] = 0.
- [31:16] = 16'hA5A5.
- [15:0] = sequence number, 0-based, zero-extended `tx_count`.

FSM, transitions checked each cycle:
- IDLE: on `start`, clear the counters, `rx_err` and `rx_last`, then go to TX_POLL.
- TX_POLL: if `tx_count`==`NUM_TX`, go to RX_POLL. Otherwise issue a read of 11 and go to TX_CHK.
- TX_CHK: if `d_out[0]`=0, go to TX_WR; else go to RX_POLL.
- TX_WR: write the packet to 10, increment `tx_count`, go to RX_POLL.
- RX_POLL: issue a read of 01, go to RX_CHK.
- RX_CHK: if `d_out[0]`=1, go to RX_RD. Otherwise go to DONE if both counts are complete, else TX_POLL.
- RX_RD: issue a read of 00, go to RX_CAP.
- RX_CAP: latch `d_out` into `rx_last` and increment `rx_count`. Set `rx_err` if [31:16]≠16'hA5A5, or if `rx_count` was already `NUM_RX` (unexpected packet). Then go to TX_POLL.
- DONE: `done`=1. RX polling stops. `start` returns to IDLE-equivalent clearing, then TX_POLL.

Arithmetic and boundary rules:
- Counters saturate at 255.
- `NUM_TX`=0 skips TX entirely. `NUM_RX`=0 means DONE once TX completes and the input status reads empty.
- Completion is checked only in RX_CHK, after an empty status read, so a packet already waiting is drained before DONE.

## Timing
- Reset values: `addr`=0, `d_in`=0, `nicEn`=0, `nicEnWR`=0, `tx_count`=0, `rx_count`=0, `rx_err`=0, `rx_last`=0, `done`=0. FSM in IDLE.
- All outputs are registered.
- NIC access occupies exactly one cycle with `nicEn`=1. In every other cycle `nicEn`=0 and `nicEnWR`=0.
- Read: `d_out` is sampled in the cycle after the access cycle (1-cycle NIC read latency).
- Write: `addr`, `d_in` and `nicEnWR` are stable for the single access cycle.
- Minimum iteration is 2 cycles for TX polling plus 2 for RX polling. A full iteration (send + receive) is 7 cycles.
- Reset asserted mid-run aborts immediately, with no further NIC access. A partially sent sequence is not resumed.

## Structure
- Package `noc_pkg`:
  - `PACKET_WIDTH`.
  - NIC address constants `NIC_IN_BUF`, `NIC_IN_STAT`, `NIC_OUT_BUF`, `NIC_OUT_STAT`.
  - Packet field bit positions.
  - Signature 16'hA5A5.
  - FSM state enum.
- Sub-module `pkt_hdr_gen`: a combinational header builder taking SRC/DST to header bits [63:32]. It is reusable by later traffic generators.

## Test plan
- Reset while `nicEn`=1 mid-TX_WR: all outputs return to their reset values asynchronously, and no access occurs after release until `start`.
- `SRC`=(0,0), `DST`=(3,3), NIC model never full: the first write is d_in=64'h6033_0000_A5A5_0000, and `tx_count` reaches 8.
- NIC model reports output full for 5 polls: no write to 10 during that time, RX polling continues, and the write happens on the first not-full status.
- Loop back 8 transmitted packets into the input buffer: `rx_count`=8, `rx_err`=0, `rx_last[15:0]`=7, `done`=1.
- Inject a packet with [31:16]=16'h1234: `rx_err`=1 and remains set through DONE.
- `NUM_TX`=0, `NUM_RX`=0, input empty: `done`=1 within 3 cycles of `start`, with no write access.
